// File: rtl/debug_ring_vc_xover.sv
// debug_ring_vc_xover
// Ring-closure block for the DII debug ring. A flit accepted on input VC k
// (k < NUM_VC-1) is buffered in FIFO k and re-emitted on output VC k+1.
// Output VC 0 is permanently idle. The top input VC is a sink that always
// accepts and, when enabled, counts the packets it swallows.
//
// Ports
//   clk        : clock
//   rst        : asynchronous active-low reset
//   in_data    : NUM_VC x DATA_WIDTH flit payload from the last ring segment
//   in_last    : per-VC end-of-packet flag
//   in_valid   : per-VC flit valid
//   in_ready   : per-VC accept (depends only on registered FIFO state)
//   out_data   : NUM_VC x DATA_WIDTH payload to the debug interface ring input
//   out_last   : per-VC end-of-packet flag
//   out_valid  : per-VC valid
//   out_ready  : per-VC downstream accept
//   drop_count : saturating count of packets sunk on the top VC
//   drop_pulse : one-cycle strobe per sunk packet
//
// Configuration
//   DEBUG_RING_XOVER_DROP_CNT_EN : when defined, drop_count/drop_pulse are
//   implemented; otherwise both are tied to zero and no counter flops exist.

module debug_ring_vc_xover #(
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_VC*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_VC-1:0]            in_last,
    input  logic [NUM_VC-1:0]            in_valid,
    output logic [NUM_VC-1:0]            in_ready,
    output logic [NUM_VC*DATA_WIDTH-1:0] out_data,
    output logic [NUM_VC-1:0]            out_last,
    output logic [NUM_VC-1:0]            out_valid,
    input  logic [NUM_VC-1:0]            out_ready,
    output logic [CNT_WIDTH-1:0]         drop_count,
    output logic                         drop_pulse
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
    localparam int unsigned TOP     = NUM_VC - 1;

    // Output VC 0 has no source: nothing crosses over into it.
    assign out_valid[0]              = 1'b0;
    assign out_last[0]               = 1'b0;
    assign out_data[DATA_WIDTH-1:0]  = '0;

    // Top VC is a pure sink and never back-pressures.
    assign in_ready[TOP] = 1'b1;

    // One registered FIFO per crossover channel: input VC k -> output VC k+1.
    for (genvar k = 0; k < int'(TOP); k++) begin : g_fifo
        logic [ENTRY_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]   r_wr_ptr;
        logic [PTR_W-1:0]   r_rd_ptr;
        logic [CNT_W-1:0]   r_count;
        logic               w_full;
        logic               w_empty;
        logic               w_push;
        logic               w_pop;
        logic [ENTRY_W-1:0] w_head;

        assign w_full  = (r_count == CNT_W'(DEPTH));
        assign w_empty = (r_count == '0);
        // Push is gated by the registered full flag only, so a pop in the
        // same cycle cannot make room until the next cycle.
        assign w_push  = in_valid[k] && !w_full;
        // Pop only what is already stored: no same-cycle fall-through.
        assign w_pop   = out_ready[k+1] && !w_empty;
        assign w_head  = r_mem[r_rd_ptr];

        // Pointer and occupancy tracking.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage array; contents are don't-care while the slot is empty.
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_last[k], in_data[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end

        assign in_ready[k]    = !w_full;
        assign out_valid[k+1] = !w_empty;
        // Head is masked while empty so idle outputs read as zero.
        assign out_last[k+1]  = !w_empty && w_head[DATA_WIDTH];
        assign out_data[(k+1)*DATA_WIDTH +: DATA_WIDTH] =
            w_empty ? '0 : w_head[DATA_WIDTH-1:0];
    end

`ifdef DEBUG_RING_XOVER_DROP_CNT_EN
    logic [CNT_WIDTH-1:0] r_drop_count;
    logic                 r_drop_pulse;
    logic                 w_drop;

    // The sink always accepts, so every valid flit with last ends a packet.
    assign w_drop = in_valid[TOP] && in_last[TOP];

    // Saturating packet counter and strobe for the top-VC sink.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}})) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

    assign drop_count = r_drop_count;
    assign drop_pulse = r_drop_pulse;
`else
    assign drop_count = '0;
    assign drop_pulse = 1'b0;
`endif

    // Sunk payload and the ready of the idle output VC are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{in_data[TOP*DATA_WIDTH +: DATA_WIDTH], in_last[TOP],
                        in_valid[TOP], out_ready[0]};

endmodule

// File: tb/tb_debug_ring_vc_xover.sv
// Directed self-checking bench for debug_ring_vc_xover with NUM_VC=3, DEPTH=4,
// CNT_WIDTH=3 (so drop-counter saturation is reachable in a few packets).

module tb_debug_ring_vc_xover;

    localparam int unsigned NUM_VC = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DW     = 16;
    localparam int unsigned CW     = 3;

`ifdef DEBUG_RING_XOVER_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [NUM_VC*DW-1:0]   in_data;
    logic [NUM_VC-1:0]      in_last;
    logic [NUM_VC-1:0]      in_valid;
    logic [NUM_VC-1:0]      in_ready;
    logic [NUM_VC*DW-1:0]   out_data;
    logic [NUM_VC-1:0]      out_last;
    logic [NUM_VC-1:0]      out_valid;
    logic [NUM_VC-1:0]      out_ready;
    logic [CW-1:0]          drop_count;
    logic                   drop_pulse;

    int n_checks;
    int n_errors;
    int n_pulses;
    logic [15:0] q1 [$];
    logic [15:0] exp_bp [6];

    debug_ring_vc_xover #(
        .NUM_VC     (NUM_VC),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every flit handed over on output VC 1.
    always @(posedge clk) begin
        if (rst && out_valid[1] && out_ready[1]) begin
            q1.push_back(out_data[31:16]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_pulses = 0;
        rst       = 1'b1;
        in_data   = '0;
        in_last   = '0;
        in_valid  = '0;
        out_ready = '0;
        #2;
        rst = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            in_data   = 48'({$urandom, $urandom});
            in_last   = 3'($urandom);
            in_valid  = 3'($urandom);
            out_ready = 3'($urandom);
            tick();
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_data", 32'(out_data[47:16]), 32'h0);
            chk("rst_drop_count", 32'(drop_count), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h7);
        end

        in_data   = '0;
        in_last   = '0;
        in_valid  = '0;
        out_ready = 3'b111;
        rst       = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'h7);
        q1.delete();

        // Crossover: 3-flit packet on VC0, single flit on VC1.
        in_valid = 3'b011;
        in_data[15:0]  = 16'h1111; in_last[0] = 1'b0;
        in_data[31:16] = 16'h00AA; in_last[1] = 1'b1;
        tick();
        chk("xo_v1_first", 32'(out_valid[1]), 32'h1);
        chk("xo_d1_first", 32'(out_data[31:16]), 32'h1111);
        chk("xo_l1_first", 32'(out_last[1]), 32'h0);
        chk("xo_v2", 32'(out_valid[2]), 32'h1);
        chk("xo_d2", 32'(out_data[47:32]), 32'h00AA);
        chk("xo_l2", 32'(out_last[2]), 32'h1);
        chk("xo_v0", 32'(out_valid[0]), 32'h0);
        in_valid = 3'b001;
        in_data[15:0] = 16'h2222;
        tick();
        chk("xo_d1_second", 32'(out_data[31:16]), 32'h2222);
        chk("xo_v2_drained", 32'(out_valid[2]), 32'h0);
        in_data[15:0] = 16'h3333; in_last[0] = 1'b1;
        tick();
        chk("xo_d1_third", 32'(out_data[31:16]), 32'h3333);
        chk("xo_l1_third", 32'(out_last[1]), 32'h1);
        in_valid = '0; in_last = '0;
        tick();
        chk("xo_v1_idle", 32'(out_valid[1]), 32'h0);
        chk("xo_v0_idle", 32'(out_valid[0]), 32'h0);
        chk("xo_q_size", 32'(q1.size()), 32'd3);
        if (q1.size() == 3) begin
            chk("xo_q0", 32'(q1[0]), 32'h1111);
            chk("xo_q1", 32'(q1[1]), 32'h2222);
            chk("xo_q2", 32'(q1[2]), 32'h3333);
        end

        // Backpressure: fill FIFO 0 with output VC1 stalled.
        q1.delete();
        for (int i = 0; i < 6; i++) exp_bp[i] = 16'(16'hA0 + i);
        out_ready[1] = 1'b0;
        in_valid[0]  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data[15:0] = exp_bp[i];
            chk("bp_ready_fill", 32'(in_ready[0]), 32'h1);
            tick();
        end
        chk("bp_ready_full", 32'(in_ready[0]), 32'h0);
        in_data[15:0] = exp_bp[4];
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold_data", 32'(out_data[31:16]), 32'h00A0);
            chk("bp_hold_ready", 32'(in_ready[0]), 32'h0);
        end
        out_ready[1] = 1'b1;
        #1;
        chk("bp_full_pop_ready", 32'(in_ready[0]), 32'h0);
        tick();
        chk("bp_ready_rise", 32'(in_ready[0]), 32'h1);
        chk("bp_head_a1", 32'(out_data[31:16]), 32'h00A1);
        tick();
        chk("bp_head_a2", 32'(out_data[31:16]), 32'h00A2);
        in_data[15:0] = exp_bp[5];
        tick();
        chk("bp_head_a3", 32'(out_data[31:16]), 32'h00A3);
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained", 32'(out_valid[1]), 32'h0);
        chk("bp_q_size", 32'(q1.size()), 32'd6);
        if (q1.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("bp_order", 32'(q1[i]), 32'(exp_bp[i]));
        end

        // Simultaneous push and pop at occupancy 2.
        out_ready[1] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[15:0] = 16'hB0; tick();
        in_data[15:0] = 16'hB1; tick();
        out_ready[1] = 1'b1;
        in_data[15:0] = 16'hB2; tick();
        chk("pp_head", 32'(out_data[31:16]), 32'h00B1);
        out_ready[1] = 1'b0;
        in_data[15:0] = 16'hB3; tick();
        chk("pp_ready_cnt3", 32'(in_ready[0]), 32'h1);
        in_data[15:0] = 16'hB4; tick();
        chk("pp_ready_cnt4", 32'(in_ready[0]), 32'h0);
        in_valid[0]  = 1'b0;
        out_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pp_drained", 32'(out_valid[1]), 32'h0);

        // Drop counting on the top VC: 5 packet ends among 6 flits.
        out_ready = 3'b111;
        in_valid  = 3'b100;
        for (int i = 0; i < 6; i++) begin
            in_data[47:32] = 16'(16'hC0 + i);
            in_last[2] = (i != 2);
            chk("drop_in_ready", 32'(in_ready[2]), 32'h1);
            tick();
            n_pulses += int'(drop_pulse);
        end
        in_valid = '0; in_last = '0;
        tick();
        chk("drop_pulse_idle", 32'(drop_pulse), 32'h0);
        chk("drop_count_5", 32'(drop_count), CNT_EN ? 32'd5 : 32'd0);
        chk("drop_pulses_5", 32'(n_pulses), CNT_EN ? 32'd5 : 32'd0);
        chk("drop_no_leak_v2", 32'(out_valid[2]), 32'h0);
        in_valid = 3'b100; in_last[2] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_valid = '0; in_last = '0;
        tick();
        chk("drop_count_sat", 32'(drop_count), CNT_EN ? 32'd7 : 32'd0);

        // Channel independence: out VC1 stalled, VC1->out VC2 streams.
        out_ready = 3'b101;
        in_valid  = 3'b011;
        in_data[15:0] = 16'h00C0;
        for (int i = 0; i < 6; i++) begin
            in_data[31:16] = 16'(16'hD0 + i);
            chk("ind_ready1", 32'(in_ready[1]), 32'h1);
            tick();
            chk("ind_v2", 32'(out_valid[2]), 32'h1);
            chk("ind_d2", 32'(out_data[47:32]), 32'(16'hD0 + i));
            chk("ind_d1_stable", 32'(out_data[31:16]), 32'h00C0);
        end
        chk("ind_ready0_full", 32'(in_ready[0]), 32'h0);
        in_valid  = '0;
        out_ready = 3'b111;
        for (int i = 0; i < 5; i++) tick();
        chk("ind_drained", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
